pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
// PURPOSE
//   Parametrised pipeline control for the LA32 core; supersedes the fixed-depth control block.
//   Sits beside the N-stage pipe, stage 0 = fetch ... stage N-1 = commit.
//   Merges per-stage stall and branch-flush requests with the commit-stage exception.
//   Runs the IDLE instruction wait state using the CSR IdleFlashAble / IDleStopAble bits.
//   Produces per-stage stall/flush masks (combinational) and one registered fetch redirect.
// PARAMETERS
//   NUM_STAGES  5             pipeline depth; legal range 3..8
//   PC_WIDTH    32            PC width
//   RESET_PC    32'h1c000000  RedirectPc reset value
//   CNT_WIDTH   32            perf counter width (only when CTRL_PERF_CNT_EN is defined)
// PORTS
//   Clk            in   1              core clock
//   Rest           in   1              asynchronous reset, active-high
//   StallReq       in   NUM_STAGES     bit i: stage i cannot advance
//   FlushReq       in   NUM_STAGES     bit i: stage i resolved a mispredict
//   FlushPc        in   NUM_STAGES*PC  target PC for stage i, bits [i*PC_WIDTH +: PC_WIDTH]
//   ExcpValid      in   1              exception or interrupt taken at commit
//   ExcpPc         in   PC_WIDTH       exception entry PC
//   IdleReq        in   1              IDLE instruction at stage N-1
//   IdleNextPc     in   PC_WIDTH       PC following the IDLE instruction
//   IntPending     in   1              any enabled interrupt pending (from CSR)
//   IdleFlashAble  in   1              CSR: flush younger stages on idle entry
//   IDleStopAble   in   1              CSR: 0 = IDLE executes as a nop
//   StageStall     out  NUM_STAGES     hold stage i
//   StageFlush     out  NUM_STAGES     invalidate stage i
//   FlushAccept    out  NUM_STAGES     one-hot; FlushReq[i] was accepted this cycle
//   RedirectValid  out  1              registered fetch redirect strobe
//   RedirectPc     out  PC_WIDTH       registered redirect target
//   IdleState      out  1              core is waiting in IDLE
// BEHAVIOUR
//   Reset values: RedirectValid=0, RedirectPc=RESET_PC, IdleState=0, FSM=RUN.
//   The mask outputs are combinational, so they are 0 when all inputs are 0.
//   Stall: take h = highest i with StallReq[i]; StageStall[j]=1 for every j<=h.
//   Branch flush: take a = highest i with FlushReq[i] & ~StageStall[i].
//     Result: FlushAccept[a]=1 and StageFlush[j]=1 for every j<a.
//     A request from a stalled stage is ignored; the source holds it until accepted.
//   StageFlush[j]=1 forces StageStall[j]=0 in the same cycle.
//   ExcpValid has top priority.
//     StageFlush is all ones and StageStall is all zeros.
//     FlushAccept=0, IdleReq is ignored, and the FSM goes to RUN from any state.
//   Redirect has 1-cycle latency: RedirectValid/RedirectPc are registered from the accepted event.
//     Priority: ExcpPc > idle IdleNextPc > FlushPc[a].
//     RedirectValid stays high for exactly one cycle per event.
//   FSM states: RUN, IDLE_WAIT, IDLE_WAKE.
//   RUN -> IDLE_WAIT when all of: IdleReq, IDleStopAble, ~ExcpValid, ~StageStall[N-1].
//     When IdleFlashAble=1, the same cycle flushes stages 0..N-2 and redirects to IdleNextPc.
//     Idle beats a simultaneous FlushReq (commit is oldest), so FlushAccept=0.
//     IdleReq with IDleStopAble=0 is a nop: no state change and no flush.
//   IDLE_WAIT: StageStall all ones, IdleState=1; IntPending -> IDLE_WAKE.
//   IDLE_WAKE: StageStall all ones, IdleState=0; goes to RUN on the next cycle.
//   Rest asserted in any state returns the FSM to RUN asynchronously; outputs take reset values.
// CONFIGURATION
//   CTRL_PERF_CNT_EN defined: adds outputs StallCycCnt, FlushCnt, IdleCycCnt [CNT_WIDTH-1:0].
//     StallCycCnt counts cycles with StageStall[0]=1.
//     FlushCnt counts RedirectValid pulses.
//     IdleCycCnt counts cycles in IDLE_WAIT.
//     All three wrap at 2^CNT_WIDTH and reset to 0.
//   CTRL_PERF_CNT_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//   T1: N=5, StallReq=5'b00100 -> StageStall=5'b00111, StageFlush=0, no redirect.
//   T2: FlushReq=5'b01010, FlushPc[3]=0x1c000100 -> FlushAccept=5'b01000, StageFlush=5'b00111;
//       next cycle RedirectValid=1, RedirectPc=0x1c000100.
//   T3: StallReq=5'b10000 with FlushReq=5'b01000 -> FlushAccept=0, StageStall=5'b11111.
//   T4: IdleReq=1, IDleStopAble=1, IdleFlashAble=1, IdleNextPc=0x1c000204.
//       Expect StageFlush=5'b01111 and Redirect=0x1c000204.
//       IdleState=1 until IntPending; one IDLE_WAKE cycle; stalls released the cycle after.
//   T5: In IDLE_WAIT, ExcpValid=1 with ExcpPc=0x1c008000 -> StageFlush=5'b11111, FSM=RUN;
//       next cycle RedirectPc=0x1c008000.
//       Also pulse Rest mid-IDLE_WAIT -> IdleState=0 immediately.
//   T6 (CTRL_PERF_CNT_EN): 7 stall cycles and 2 redirects -> StallCycCnt=7, FlushCnt=2.
//       Preload the counters to all ones and check they wrap to 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// LA32 pipeline control: merges stall/branch-flush/exception requests, runs the IDLE wait FSM,
// and drives a registered fetch redirect. Defining CTRL_PERF_CNT_EN adds stall/flush/idle counters.
module pipe_ctrl_unit #(
  parameter int                  NUM_STAGES = 5,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h1c00_0000,
  parameter int                  CNT_WIDTH  = 32
) (
  input  logic                           Clk_i,
  input  logic                           Rest_i,
  input  logic [NUM_STAGES-1:0]          StallReq_i,
  input  logic [NUM_STAGES-1:0]          FlushReq_i,
  input  logic [NUM_STAGES*PC_WIDTH-1:0] FlushPc_i,
  input  logic                           ExcpValid_i,
  input  logic [PC_WIDTH-1:0]            ExcpPc_i,
  input  logic                           IdleReq_i,
  input  logic [PC_WIDTH-1:0]            IdleNextPc_i,
  input  logic                           IntPending_i,
  input  logic                           IdleFlashAble_i,
  input  logic                           IDleStopAble_i,
  output logic [NUM_STAGES-1:0]          StageStall_o,
  output logic [NUM_STAGES-1:0]          StageFlush_o,
  output logic [NUM_STAGES-1:0]          FlushAccept_o,
  output logic                           RedirectValid_o,
  output logic [PC_WIDTH-1:0]            RedirectPc_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]           StallCycCnt_o,
  output logic [CNT_WIDTH-1:0]           FlushCnt_o,
  output logic [CNT_WIDTH-1:0]           IdleCycCnt_o,
`endif
  output logic                           IdleState_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IDLE_WAIT = 2'd1,
    ST_IDLE_WAKE = 2'd2
  } state_e;

  localparam logic [NUM_STAGES-1:0] ALL_ONES   = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] IDLE_FLUSH = {1'b0, {(NUM_STAGES-1){1'b1}}};

  state_e                state_q;
  logic                  idle_state_q;
  logic                  redir_valid_q;
  logic                  redir_valid_d;
  logic [PC_WIDTH-1:0]   redir_pc_q;
  logic [PC_WIDTH-1:0]   redir_pc_d;
  logic [PC_WIDTH-1:0]   br_pc_s;
  logic [NUM_STAGES-1:0] stall_pre_s;
  logic [NUM_STAGES-1:0] accept_s;
  logic [NUM_STAGES-1:0] younger_s;
  logic [NUM_STAGES-1:0] stall_s;
  logic [NUM_STAGES-1:0] flush_s;
  logic [NUM_STAGES-1:0] acc_out_s;
  logic                  idle_go_s;

  // Scan from commit toward fetch: stall reaches every stage at or below the highest request,
  // and the oldest unstalled flush wins, flushing everything younger than it.
  always_comb begin
    logic stall_acc;
    logic found;
    stall_acc   = 1'b0;
    found       = 1'b0;
    stall_pre_s = '0;
    accept_s    = '0;
    younger_s   = '0;
    br_pc_s     = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      stall_acc      = stall_acc | StallReq_i[i];
      stall_pre_s[i] = stall_acc | (state_q != ST_RUN);
    end
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      younger_s[i] = found;
      accept_s[i]  = FlushReq_i[i] & ~stall_pre_s[i] & ~found;
      found        = found | accept_s[i];
      br_pc_s      = br_pc_s | (FlushPc_i[i*PC_WIDTH +: PC_WIDTH] & {PC_WIDTH{accept_s[i]}});
    end
  end

  assign idle_go_s = (state_q == ST_RUN) & IdleReq_i & IDleStopAble_i & ~ExcpValid_i
                   & ~stall_pre_s[NUM_STAGES-1];

  // Event priority: exception, then idle entry (commit is oldest), then branch flush.
  always_comb begin
    stall_s       = stall_pre_s;
    flush_s       = '0;
    acc_out_s     = '0;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    if (ExcpValid_i) begin
      stall_s       = '0;
      flush_s       = ALL_ONES;
      redir_valid_d = 1'b1;
      redir_pc_d    = ExcpPc_i;
    end else if (idle_go_s) begin
      if (IdleFlashAble_i) begin
        flush_s       = IDLE_FLUSH;
        stall_s       = stall_pre_s & ~IDLE_FLUSH;
        redir_valid_d = 1'b1;
        redir_pc_d    = IdleNextPc_i;
      end else begin
        stall_s = stall_pre_s;
      end
    end else if (|accept_s) begin
      flush_s       = younger_s;
      stall_s       = stall_pre_s & ~younger_s;
      acc_out_s     = accept_s;
      redir_valid_d = 1'b1;
      redir_pc_d    = br_pc_s;
    end else begin
      stall_s = stall_pre_s;
    end
  end

  // IDLE FSM with registered idle flag and fetch redirect.
  always_ff @(posedge Clk_i or posedge Rest_i) begin
    if (Rest_i) begin
      state_q       <= ST_RUN;
      idle_state_q  <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= RESET_PC;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      if (ExcpValid_i) begin
        state_q      <= ST_RUN;
        idle_state_q <= 1'b0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (idle_go_s) begin
              state_q      <= ST_IDLE_WAIT;
              idle_state_q <= 1'b1;
            end else begin
              state_q      <= ST_RUN;
              idle_state_q <= 1'b0;
            end
          end
          ST_IDLE_WAIT: begin
            if (IntPending_i) begin
              state_q      <= ST_IDLE_WAKE;
              idle_state_q <= 1'b0;
            end else begin
              state_q      <= ST_IDLE_WAIT;
              idle_state_q <= 1'b1;
            end
          end
          ST_IDLE_WAKE: begin
            state_q      <= ST_RUN;
            idle_state_q <= 1'b0;
          end
          default: begin
            state_q      <= ST_RUN;
            idle_state_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign StageStall_o    = stall_s;
  assign StageFlush_o    = flush_s;
  assign FlushAccept_o   = acc_out_s;
  assign RedirectValid_o = redir_valid_q;
  assign RedirectPc_o    = redir_pc_q;
  assign IdleState_o     = idle_state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cyc_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;
  logic [CNT_WIDTH-1:0] idle_cyc_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge Clk_i or posedge Rest_i) begin
    if (Rest_i) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
      idle_cyc_q  <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_q + {{(CNT_WIDTH-1){1'b0}}, stall_s[0]};
      flush_cnt_q <= flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, redir_valid_q};
      idle_cyc_q  <= idle_cyc_q + {{(CNT_WIDTH-1){1'b0}}, (state_q == ST_IDLE_WAIT)};
    end
  end

  assign StallCycCnt_o = stall_cyc_q;
  assign FlushCnt_o    = flush_cnt_q;
  assign IdleCycCnt_o  = idle_cyc_q;
`endif

endmodule
